// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, request-op enum and request payload type.
package mips_pkg;

   localparam int unsigned OPC_W   = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned TGT_W   = 26;
   localparam int unsigned WORD_W  = 32;

   localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
   localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
   localparam logic [OPC_W-1:0] OPC_SLTI  = 6'h0A;
   localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
   localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;
   localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
   localparam logic [OPC_W-1:0] OPC_J     = 6'h02;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      REQ_R       = 3'd0,
      REQ_ADDI    = 3'd1,
      REQ_SLTI    = 3'd2,
      REQ_LW      = 3'd3,
      REQ_SW      = 3'd4,
      REQ_BEQ     = 3'd5,
      REQ_J       = 3'd6,
      REQ_ILLEGAL = 3'd7
   } req_op_e;

   typedef struct packed {
      logic [REG_W-1:0]   rs;
      logic [REG_W-1:0]   rt;
      logic [REG_W-1:0]   rd;
      logic [FUNCT_W-1:0] funct;
      logic [IMM_W-1:0]   imm;
      logic [TGT_W-1:0]   target;
   } instr_fields_t;

   // True for the R-type function codes the encoder supports.
   function automatic logic is_known_funct(input logic [FUNCT_W-1:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
             (fn == FN_OR)  || (fn == FN_SLT);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational instruction packer: request op + fields -> 32-bit word + illegal flag.
// Optional field sanity checks are compiled in with ENC_FIELD_CHECK_EN.
module instr_pack
   import mips_pkg::*;
(
   input  logic [2:0]        req_op,
   input  instr_fields_t     fields,
   output logic [WORD_W-1:0] word_c,
   output logic              illegal_c
);

   // Pack fields per instruction format and flag requests that must not be written.
   always_comb begin
      word_c    = '0;
      illegal_c = 1'b0;
      case (req_op_e'(req_op))
         REQ_R:    word_c = {OPC_RTYPE, fields.rs, fields.rt, fields.rd, 5'b00000, fields.funct};
         REQ_ADDI: word_c = {OPC_ADDI, fields.rs, fields.rt, fields.imm};
         REQ_SLTI: word_c = {OPC_SLTI, fields.rs, fields.rt, fields.imm};
         REQ_LW:   word_c = {OPC_LW,   fields.rs, fields.rt, fields.imm};
         REQ_SW:   word_c = {OPC_SW,   fields.rs, fields.rt, fields.imm};
         REQ_BEQ:  word_c = {OPC_BEQ,  fields.rs, fields.rt, fields.imm};
         REQ_J:    word_c = {OPC_J,    fields.target};
         default:  illegal_c = 1'b1;
      endcase
`ifdef ENC_FIELD_CHECK_EN
      if (req_op_e'(req_op) == REQ_R &&
          (fields.rd == '0 || !is_known_funct(fields.funct)))
         illegal_c = 1'b1;
      if ((req_op_e'(req_op) == REQ_ADDI || req_op_e'(req_op) == REQ_SLTI ||
           req_op_e'(req_op) == REQ_LW) && fields.rt == '0)
         illegal_c = 1'b1;
`endif
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode requests and writes packed words
// sequentially into an instruction memory image until full.
// Optional macro: ENC_FIELD_CHECK_EN (enables register/funct field rejection).
module instr_encoder
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [5:0]        funct,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              full,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned     CNT_W     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e            state;
   instr_fields_t     fields_c;
   logic [WORD_W-1:0] word_c;
   logic              illegal_c;
   logic              accept_c;

   assign fields_c = '{rs: rs, rt: rt, rd: rd, funct: funct, imm: imm, target: target};

   instr_pack u_pack (
      .req_op    (req_op),
      .fields    (fields_c),
      .word_c    (word_c),
      .illegal_c (illegal_c)
   );

   // Ready only in IDLE, out of reset, and when clear is not taking priority.
   assign req_ready = rst_n && (state == ST_IDLE) && !clear;
   assign accept_c  = req_valid && req_ready;

   // Handshake FSM, write address/count tracking and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         count      <= '0;
         full       <= 1'b0;
         err        <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         err     <= 1'b0;
         if (clear) begin
            state     <= ST_IDLE;
            imem_addr <= '0;
            count     <= '0;
            full      <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept_c) begin
                     if (illegal_c) begin
                        err <= 1'b1;
                     end else begin
                        imem_wdata <= word_c;
                        imem_we    <= 1'b1;
                        state      <= ST_WRITE;
                     end
                  end
               end
               ST_WRITE: begin
                  count <= count + CNT_W'(1);
                  // Address holds at the last word when full; it only rewinds through clear.
                  if (imem_addr == ADDR_LAST) begin
                     full  <= 1'b1;
                     state <= ST_FULL;
                  end else begin
                     imem_addr <= imem_addr + ADDR_W'(1);
                     state     <= ST_IDLE;
                  end
               end
               ST_FULL: state <= ST_FULL;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=2 so the full condition is reachable).
module tb_instr_encoder;

   localparam int unsigned ADDR_W = 2;
   localparam int          DEPTH  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, clear, req_valid;
   logic [2:0]        req_op;
   logic [4:0]        rs, rt, rd;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       target;
   logic              req_ready, imem_we, full, err;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;

   int checks = 0;
   int errors = 0;

   instr_encoder #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .full(full), .err(err), .count(count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding straight from the instruction formats.
   function automatic logic [31:0] ref_enc(input logic [2:0] op, input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] d, input logic [5:0] fn,
                                           input logic [15:0] im, input logic [25:0] tg);
      case (op)
         3'd0: return {6'h00, s, t, d, 5'd0, fn};
         3'd1: return {6'h08, s, t, im};
         3'd2: return {6'h0A, s, t, im};
         3'd3: return {6'h23, s, t, im};
         3'd4: return {6'h2B, s, t, im};
         3'd5: return {6'h04, s, t, im};
         3'd6: return {6'h02, tg};
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit ref_illegal(input logic [2:0] op, input logic [4:0] t,
                                      input logic [4:0] d, input logic [5:0] fn);
      bit bad;
      bad = (op == 3'd7);
`ifdef ENC_FIELD_CHECK_EN
      if (op == 3'd0 && (d == 5'd0 || !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}))) bad = 1'b1;
      if ((op == 3'd1 || op == 3'd2 || op == 3'd3) && t == 5'd0) bad = 1'b1;
`endif
      return bad;
   endfunction

   // Behavioural model: the memory image is described by how many words it holds,
   // whether a strobe is currently showing, and the last word presented.
   int          m_cnt   = 0;
   bit          m_busy  = 1'b0;
   bit          m_err   = 1'b0;
   bit          m_valid = 1'b0;
   logic [31:0] m_wdata = 32'h0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_cnt = 0; m_busy = 1'b0; m_err = 1'b0; m_wdata = 32'h0; m_valid = 1'b1;
      end else if (clear) begin
         m_cnt = 0; m_busy = 1'b0; m_err = 1'b0;
      end else if (m_busy) begin
         m_cnt++; m_busy = 1'b0; m_err = 1'b0;
      end else begin
         m_err = 1'b0;
         if (req_valid && m_cnt < DEPTH) begin
            if (ref_illegal(req_op, rt, rd, funct)) m_err = 1'b1;
            else begin
               m_busy  = 1'b1;
               m_wdata = ref_enc(req_op, rs, rt, rd, funct, imm, target);
            end
         end
      end
   end

   // Compare process: every output against the model on every falling edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("req_ready", 32'(req_ready), 32'(rst_n && !m_busy && m_cnt < DEPTH && !clear));
         chk("imem_we",   32'(imem_we),   32'(m_busy));
         chk("imem_addr", 32'(imem_addr), (m_cnt >= DEPTH) ? 32'(DEPTH - 1) : 32'(m_cnt));
         chk("imem_wdata", imem_wdata, m_wdata);
         chk("count",     32'(count),     32'(m_cnt));
         chk("full",      32'(full),      32'(m_cnt == DEPTH));
         chk("err",       32'(err),       32'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic set_req(input logic [2:0] op, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                          input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
      req_op = op; rs = s; rt = t; rd = d; funct = fn; imm = im; target = tg;
   endtask

   logic [5:0] legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

   initial begin
      rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0;
      set_req(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
      tick(); tick();
      rst_n = 1'b1;
      sample();
      chk("lit_reset_we", 32'(imem_we), 32'd0);
      chk("lit_reset_count", 32'(count), 32'd0);
      chk("lit_reset_ready", 32'(req_ready), 32'd1);

      // ADDI rs=1 rt=2 imm=5
      set_req(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0); req_valid = 1'b1;
      tick(); req_valid = 1'b0;
      sample();
      chk("lit_addi_we", 32'(imem_we), 32'd1);
      chk("lit_addi_addr", 32'(imem_addr), 32'd0);
      chk("lit_addi_wdata", imem_wdata, 32'h20220005);
      tick(); sample();
      chk("lit_addi_count", 32'(count), 32'd1);

      clear = 1'b1; tick(); clear = 1'b0;

      // R then J back-to-back, J held while the R write is in progress
      set_req(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0); req_valid = 1'b1;
      tick();
      set_req(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
      sample();
      chk("lit_r_wdata", imem_wdata, 32'h00221820);
      chk("lit_r_addr", 32'(imem_addr), 32'd0);
      chk("lit_r_ready", 32'(req_ready), 32'd0);
      tick(); tick(); req_valid = 1'b0;
      sample();
      chk("lit_j_wdata", imem_wdata, 32'h08000010);
      chk("lit_j_addr", 32'(imem_addr), 32'd1);
      chk("lit_j_ready", 32'(req_ready), 32'd0);
      tick();

      // LW rs=29 rt=8 imm=4
      set_req(3'd3, 5'd29, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0); req_valid = 1'b1;
      tick(); req_valid = 1'b0;
      sample();
      chk("lit_lw_wdata", imem_wdata, 32'h8FA80004);
      tick();

      // Illegal op
      set_req(3'd7, 5'd1, 5'd1, 5'd1, 6'd0, 16'd0, 26'd0); req_valid = 1'b1;
      tick(); req_valid = 1'b0;
      sample();
      chk("lit_ill_err", 32'(err), 32'd1);
      chk("lit_ill_we", 32'(imem_we), 32'd0);
      tick(); sample();
      chk("lit_ill_err_gone", 32'(err), 32'd0);
      chk("lit_ill_count", 32'(count), 32'd3);

      // R with rd=0
      set_req(3'd0, 5'd1, 5'd2, 5'd0, 6'h20, 16'd0, 26'd0); req_valid = 1'b1;
      tick(); req_valid = 1'b0;
      sample();
`ifdef ENC_FIELD_CHECK_EN
      chk("lit_rd0_err", 32'(err), 32'd1);
      chk("lit_rd0_we", 32'(imem_we), 32'd0);
`else
      chk("lit_rd0_we", 32'(imem_we), 32'd1);
      chk("lit_rd0_wdata", imem_wdata, 32'h00220020);
`endif
      tick();

      // Fill the image, then hold a fifth request
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         set_req(3'd1, 5'(i + 1), 5'd2, 5'd0, 6'd0, 16'(i), 26'd0); req_valid = 1'b1;
         tick(); req_valid = 1'b0; tick();
      end
      sample();
      chk("lit_full", 32'(full), 32'd1);
      chk("lit_full_ready", 32'(req_ready), 32'd0);
      chk("lit_full_count", 32'(count), 32'd4);
      req_valid = 1'b1;
      tick(); tick(); tick();
      sample();
      chk("lit_full_no_we", 32'(imem_we), 32'd0);
      clear = 1'b1; tick(); clear = 1'b0;
      sample();
      chk("lit_clr_addr", 32'(imem_addr), 32'd0);
      chk("lit_clr_full", 32'(full), 32'd0);
      tick(); req_valid = 1'b0;
      sample();
      chk("lit_after_clr_we", 32'(imem_we), 32'd1);
      chk("lit_after_clr_addr", 32'(imem_addr), 32'd0);
      tick();

      // clear with req_valid in IDLE
      req_valid = 1'b1; clear = 1'b1;
      sample();
      chk("lit_clr_ready", 32'(req_ready), 32'd0);
      tick(); clear = 1'b0; req_valid = 1'b0;
      sample();
      chk("lit_clr_no_we", 32'(imem_we), 32'd0);
      tick();

      // Reset during WRITE
      req_valid = 1'b1;
      tick(); req_valid = 1'b0;
      sample();
      chk("lit_rstw_we", 32'(imem_we), 32'd1);
      rst_n = 1'b0;
      tick(); sample();
      chk("lit_rstw_we_off", 32'(imem_we), 32'd0);
      chk("lit_rstw_wdata", imem_wdata, 32'h0);
      chk("lit_rstw_count", 32'(count), 32'd0);
      chk("lit_rstw_ready", 32'(req_ready), 32'd0);
      tick(); rst_n = 1'b1;

      // Randomized phase
      for (int n = 0; n < 3000; n++) begin
         rst_n     = ($urandom_range(99) != 0);
         clear     = ($urandom_range(24) == 0);
         req_valid = ($urandom_range(9) < 7);
         req_op    = ($urandom_range(9) == 0) ? 3'd7 : 3'($urandom_range(6));
         rs        = 5'($urandom);
         rt        = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom);
         rd        = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom);
         funct     = ($urandom_range(3) != 0) ? legal_fn[$urandom_range(4)] : 6'($urandom);
         imm       = 16'($urandom);
         target    = 26'($urandom);
         tick();
      end
      rst_n = 1'b1; clear = 1'b0; req_valid = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
